// File: rtl/inert_spi_intf.sv
`timescale 1ns/1ps
// Inertial sensor SPI master: power-on wait, configuration writes, then a 10-read burst per data-ready interrupt.
// Latency: 257-clk frames with a 2-clk gap; vld follows the last read by one clk.
// No backpressure: the five data words are overwritten on each pass, so consumers must sample on vld.
module inert_spi_intf #(
    parameter logic [17:0] POR_WAIT = 18'h20000,
    parameter int          DIV_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic        INT,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic        vld,
    output logic        init_done
);

    localparam logic [DIV_W-1:0] DIV_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_HALF = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [6:0]       RD_BASE  = 7'h22;

    typedef enum logic [1:0] {E_IDLE, E_SHIFT, E_BACK} eng_t;
    typedef enum logic [1:0] {S_PORW, S_CFG, S_WINT, S_RD} seq_t;

    eng_t              eng_state, eng_next;
    seq_t              seq_state, seq_next;
    logic [DIV_W-1:0]  div;
    logic [3:0]        bit_cnt;
    logic [15:0]       shreg;
    logic              miso_smpl;
    logic              done;
    logic              start;
    logic [15:0]       cmd;
    logic [7:0]        rd_data;
    logic              int_m, int_s;
    logic [17:0]       por_cnt;
    logic [3:0]        idx;
    logic              wait_d;
    logic [7:0]        hold;

    assign SS_n    = (eng_state == E_IDLE);
    assign SCLK    = SS_n ? 1'b1 : div[DIV_W-1];
    assign MOSI    = shreg[15];
    assign rd_data = shreg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            int_m <= 1'b0;
            int_s <= 1'b0;
        end else begin
            int_m <= INT;
            int_s <= int_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) eng_state <= E_IDLE;
        else     eng_state <= eng_next;
    end

    always_comb begin
        eng_next = eng_state;
        case (eng_state)
            E_IDLE:  if (start) eng_next = E_SHIFT;
            E_SHIFT: if (div == DIV_MAX && bit_cnt == 4'd15) eng_next = E_BACK;
            E_BACK:  eng_next = E_IDLE;
            default: eng_next = E_IDLE;
        endcase
    end

    // The last bit's shift leaves div at all-ones so SCLK stays high through the back porch.
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            miso_smpl <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (eng_state)
                E_IDLE: begin
                    if (start) begin
                        div     <= '0;
                        bit_cnt <= '0;
                        shreg   <= cmd;
                    end
                end
                E_SHIFT: begin
                    if (div == DIV_HALF) miso_smpl <= MISO;
                    if (div == DIV_MAX) begin
                        shreg <= {shreg[14:0], miso_smpl};
                        if (bit_cnt != 4'd15) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            div     <= '0;
                        end
                    end else begin
                        div <= div + DIV_ONE;
                    end
                end
                E_BACK:  done <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) seq_state <= S_PORW;
        else     seq_state <= seq_next;
    end

    always_comb begin
        seq_next = seq_state;
        start    = 1'b0;
        cmd      = 16'h0000;
        case (seq_state)
            S_PORW: if (por_cnt == POR_WAIT - 18'd1) seq_next = S_CFG;
            S_CFG: begin
                case (idx)
                    4'd0:    cmd = 16'h0D02;
                    4'd1:    cmd = 16'h1062;
                    default: cmd = 16'h1162;
                endcase
                start = (eng_state == E_IDLE) && !wait_d;
                if (done && idx == 4'd2) seq_next = S_WINT;
            end
            S_WINT: if (int_s) seq_next = S_RD;
            S_RD: begin
                cmd   = {1'b1, RD_BASE + {3'b000, idx}, 8'h00};
                start = (eng_state == E_IDLE) && !wait_d;
                if (done && idx == 4'd9) seq_next = S_WINT;
            end
            default: seq_next = S_PORW;
        endcase
    end

    // wait_d blocks a relaunch until the in-flight frame's done has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            por_cnt   <= '0;
            idx       <= '0;
            wait_d    <= 1'b0;
            hold      <= '0;
            ptch      <= '0;
            roll      <= '0;
            yaw       <= '0;
            ax        <= '0;
            ay        <= '0;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (seq_state == S_PORW) por_cnt <= por_cnt + 18'd1;
            if (start)     wait_d <= 1'b1;
            else if (done) wait_d <= 1'b0;
            if (done && seq_state == S_CFG) begin
                if (idx == 4'd2) begin
                    idx       <= '0;
                    init_done <= 1'b1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
            if (done && seq_state == S_RD) begin
                if (!idx[0]) begin
                    hold <= rd_data;
                end else begin
                    case (idx[3:1])
                        3'd0:    ptch <= {rd_data, hold};
                        3'd1:    roll <= {rd_data, hold};
                        3'd2:    yaw  <= {rd_data, hold};
                        3'd3:    ax   <= {rd_data, hold};
                        default: begin
                            ay  <= {rd_data, hold};
                            vld <= 1'b1;
                        end
                    endcase
                end
                idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_inert_spi_intf.sv
`timescale 1ns/1ps
// Directed bench for inert_spi_intf with a behavioural iNEMO SPI slave model.
module tb_inert_spi_intf;

    localparam logic [17:0] PW = 18'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n, SCLK, MOSI, MISO, INT;
    logic [15:0] ptch, roll, yaw, ax, ay;
    logic        vld, init_done;

    int total = 0;
    int bad   = 0;

    // sensor model state
    logic        miso_r = 1'b0;
    logic        int_pend = 1'b0;
    logic        sclk_q = 1'b1;
    logic        ssn_q = 1'b1;
    logic [15:0] rx = 16'h0;
    logic [7:0]  tx = 8'h0;
    int          bcnt = 0, rises = 0, lowc = 0;
    logic [15:0] f_word[$];
    int          f_rises[$];
    int          f_low[$];
    logic [7:0]  regs [128];
    int          vld_cnt = 0;
    int          int_req = 0, int_seen = 0;
    logic [15:0] d_ptch = 16'h1234, d_roll = 16'hABCD, d_yaw = 16'h8001,
                 d_ax = 16'h00FF, d_ay = 16'hFF00;

    assign MISO = miso_r;
    assign INT  = int_pend;

    always #5 clk = ~clk;

    inert_spi_intf #(.POR_WAIT(PW), .DIV_W(4)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .INT(INT), .ptch(ptch), .roll(roll), .yaw(yaw), .ax(ax), .ay(ay),
        .vld(vld), .init_done(init_done)
    );

    function automatic logic [7:0] rd_byte(input logic [6:0] a);
        case (a)
            7'h22: rd_byte = d_ptch[7:0];
            7'h23: rd_byte = d_ptch[15:8];
            7'h24: rd_byte = d_roll[7:0];
            7'h25: rd_byte = d_roll[15:8];
            7'h26: rd_byte = d_yaw[7:0];
            7'h27: rd_byte = d_yaw[15:8];
            7'h28: rd_byte = d_ax[7:0];
            7'h29: rd_byte = d_ax[15:8];
            7'h2A: rd_byte = d_ay[7:0];
            7'h2B: rd_byte = d_ay[15:8];
            default: rd_byte = regs[a];
        endcase
    endfunction

    // Mode-3 slave: sample MOSI on SCLK rise, drive MISO on SCLK fall.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 128; k++) regs[k] = 8'h00;
        end
        if (int_req != int_seen) begin
            int_pend = 1'b1;
            int_seen = int_req;
        end
        if (vld) vld_cnt++;
        if (!SS_n && ssn_q) begin
            bcnt = 0; rx = 16'h0; rises = 0; lowc = 0;
        end
        if (!SS_n) begin
            lowc++;
            if (SCLK && !sclk_q) begin
                rx = {rx[14:0], MOSI};
                bcnt++;
                rises++;
                if (bcnt == 8) tx = rd_byte(rx[6:0]);
            end
            if (!SCLK && sclk_q && bcnt >= 8) begin
                miso_r = tx[7];
                tx = {tx[6:0], 1'b0};
            end
        end
        if (SS_n && !ssn_q) begin
            f_word.push_back(rx);
            f_rises.push_back(rises);
            f_low.push_back(lowc);
            if (bcnt == 16 && !rx[15]) regs[rx[14:8]] = rx[7:0];
            if (bcnt == 16 && rx[15:8] == 8'hA2) int_pend = 1'b0;
        end
        sclk_q = SCLK;
        ssn_q  = SS_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int base;
        logic [15:0] cfg_w [3];
        logic [7:0]  a;
        cfg_w[0] = 16'h0D02; cfg_w[1] = 16'h1062; cfg_w[2] = 16'h1162;

        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_vld", vld, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ptch", ptch, 16'h0);
        chk("rst_ay", ay, 16'h0);

        rst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (SS_n && n < PW + 50);
        chk("por_wait", n, PW + 1);

        n = 0;
        while (rises != 5 && n < 300) begin @(negedge clk); n++; end
        chk("reach_bit5", rises, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ss_n", SS_n, 1);
        chk("midrst_sclk", SCLK, 1);
        chk("midrst_init_done", init_done, 0);
        @(negedge clk);
        rst = 1'b0;
        int_req++;
        base = f_word.size();
        n = 0;
        do begin @(negedge clk); n++; end while (SS_n && n < PW + 50);
        chk("por_restart", n, PW + 1);

        n = 0;
        while (!init_done && n < 2000) begin @(negedge clk); n++; end
        chk("init_done_seen", init_done, 1);
        chk("cfg_frame_cnt", f_word.size() - base, 3);
        @(negedge clk);
        chk("rd_wait_ss_n", SS_n, 1);
        @(negedge clk);
        chk("rd_start_ss_n", SS_n, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cfg_word%0d", i), f_word[base+i], cfg_w[i]);
            chk($sformatf("cfg_rises%0d", i), f_rises[base+i], 16);
            chk($sformatf("cfg_low%0d", i), f_low[base+i], 257);
        end
        chk("reg_0d", regs[7'h0D], 8'h02);
        chk("reg_10", regs[7'h10], 8'h62);
        chk("reg_11", regs[7'h11], 8'h62);

        n = 0;
        while (!vld && n < 4000) begin @(negedge clk); n++; end
        chk("vld1_seen", vld, 1);
        chk("p1_ptch", ptch, 16'h1234);
        chk("p1_roll", roll, 16'hABCD);
        chk("p1_yaw", yaw, 16'h8001);
        chk("p1_ax", ax, 16'h00FF);
        chk("p1_ay", ay, 16'hFF00);
        @(negedge clk);
        chk("vld1_one_cycle", vld, 0);
        chk("p1_frame_cnt", f_word.size() - base, 13);
        for (int i = 0; i < 10; i++) begin
            a = 8'hA2 + 8'(i);
            chk($sformatf("rd_cmd%0d", i), f_word[base+3+i], {a, 8'h00});
        end
        chk("int_cleared", INT, 0);

        d_ptch = 16'h5A5A;
        int_req++;
        n = 0;
        while (!vld && n < 4000) begin @(negedge clk); n++; end
        chk("vld2_seen", vld, 1);
        chk("p2_ptch", ptch, 16'h5A5A);
        chk("p2_roll", roll, 16'hABCD);
        chk("p2_ay", ay, 16'hFF00);
        @(negedge clk);
        chk("vld2_one_cycle", vld, 0);
        chk("vld_cnt2", vld_cnt, 2);

        repeat (800) @(negedge clk);
        chk("idle_vld_cnt", vld_cnt, 2);
        chk("idle_frames", f_word.size() - base, 23);
        chk("idle_ptch_hold", ptch, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inert_spi_intf.md
Name: inert_spi_intf

Overview:
- Master-side inertial interface that drives the iNEMO 6-axis sensor over SPI.
- After a power-on wait it writes the sensor configuration registers.
- On each sensor data-ready interrupt it reads pitch, roll and yaw rates plus X/Y acceleration, and presents them as registered 16-bit words with a one-cycle valid strobe.
- Sits directly upstream of the sensor; downstream logic consumes ptch/roll/yaw/ax/ay on vld.

Parameters:
- POR_WAIT, 18'h20000: clk cycles to wait after reset before the first SPI transaction (the sensor is unresponsive for ~330 us after power-up).
- DIV_W, 4: SCLK divider width; SCLK period = 2^DIV_W clk.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: reset, synchronous, active-high.
- SS_n, output, 1: slave select, active low.
- SCLK, output, 1: serial clock, idle high.
- MOSI, output, 1: serial data to sensor.
- MISO, input, 1: serial data from sensor.
- INT, input, 1: sensor data-ready interrupt (asynchronous).
- ptch, output, 16: pitch rate, registered.
- roll, output, 16: roll rate, registered.
- yaw, output, 16: yaw rate, registered.
- ax, output, 16: X acceleration, registered.
- ay, output, 16: Y acceleration, registered.
- vld, output, 1: one-cycle pulse; new set of data on all five outputs.
- init_done, output, 1: high once configuration writes are complete; sticky until rst.

Behaviour:
- **Clock and reset:** one clock (clk); reset rst is synchronous, active-high.
- **Reset values:** SS_n=1, SCLK=1, MOSI=0, all data outputs 16'h0000, vld=0, init_done=0, all counters 0. Reset mid-transaction aborts immediately: SS_n returns to 1 and SCLK to 1 on the next edge.
- **INT synchronisation:** INT is double-flopped; only the synchronised version is used.
- **SPI engine:** 16-bit frames, mode 3.
  - Start: SS_n<=0, divider<=0, bit counter<=0, 16-bit shift register<=cmd.
  - SCLK = divider MSB.
  - Rising edge: when divider==2^DIV_W/2-1, MISO is sampled into miso_smpl.
  - Falling edge: when divider==all-ones and bit counter<15, the shift register shifts left with miso_smpl as LSB and the bit counter increments.
  - MOSI = shift register [15].
  - At divider==all-ones with bit counter==15 there is no fall. The final shift occurs, SCLK is held 1, SS_n<=1 on the next clk, and an internal done is asserted for 1 clk.
  - Read data = shift register [7:0].
  - Frame length = 16*2^DIV_W + 1 clks (257 at default).
- **Command format:**
  - Write: {1'b0, addr[6:0], data[7:0]}.
  - Read: {1'b1, addr[6:0], 8'h00}.
- **Sequencer states:**
  - PORW: count to POR_WAIT-1, then go to CFG.
  - CFG: issue writes 16'h0D02, 16'h1062, 16'h1162 in order, each after the previous done. After the third done, set init_done and go to WINT.
  - WINT: wait for synchronised INT==1, then go to RD.
  - RD: issue 10 reads in order: 8'hA2, A3, A4, A5, A6, A7, A8, A9, AA, AB (pitch L/H, roll L/H, yaw L/H, ax L/H, ay L/H).
    - Low-byte read data goes to a holding byte.
    - On each high-byte done, the {high, holding} word is written to the corresponding output.
    - The read of A2 clears the sensor's INT.
  - After the AB done: vld=1 for exactly 1 clk (the same cycle ay updates), then back to WINT.
- **Inter-frame gap:** at least 1 clk with SS_n=1 between frames.
- **INT during RD:** ignored. A new pass begins only from WINT.
- **INT already high on entering WINT:** RD starts on the next clk.
- **Output holding:** outputs hold their values between updates. Individual outputs update as their high byte lands, so consumers sample only on vld.

Test Plan:
- **Reset mid-frame:** assert rst during the 5th bit of a CFG frame -> SS_n=1, SCLK=1, init_done=0 next clk; the sequence restarts with a PORW count.
- **Configuration:** SPI_iNEMO3 model with POR_WAIT=18'h20000 -> three frames with MOSI words 16'h0D02, 16'h1062, 16'h1162; model registers 0x0D=0x02, 0x10=0x62, 0x11=0x62; init_done=1 after the third SS_n rise. Each frame shows exactly 16 SCLK rising edges with SS_n low for 257 clks.
- **Data pass:** model inputs PTCH=16'h1234, ROLL=16'hABCD, YAW=16'h8001, AX=16'h00FF, AY=16'hFF00 -> after INT, 10 read frames A2..AB, then a single-cycle vld with ptch=1234, roll=ABCD, yaw=8001, ax=00FF, ay=FF00; model INT low after the first read.
- **Repeated INT:** change PTCH to 16'h5A5A before the next INT -> second vld with ptch=5A5A; exactly one vld per INT.
- **Pre-init INT:** force INT=1 before init_done -> no read frames until CFG completes; RD starts 1 clk after init_done if INT is still high.
